// File: rtl/fp_greaterthan_pkg.sv
// Shared constants and types for the fp_greaterthan comparator.
// The word is {sign, exponent, significand}. The sign is the MSB.
// The default widths give a 13-bit word.
package fp_greaterthan_pkg;

  localparam int EXP_W_DEF = 4;
  localparam int SIG_W_DEF = 8;
  localparam int W_DEF     = 1 + EXP_W_DEF + SIG_W_DEF;

  // Field positions for the default word layout
  localparam int SIGN_POS = W_DEF - 1;
  localparam int EXP_MSB  = W_DEF - 2;
  localparam int EXP_LSB  = SIG_W_DEF;
  localparam int SIG_MSB  = SIG_W_DEF - 1;
  localparam int SIG_LSB  = 0;

  typedef logic [W_DEF-1:0] fp_word_t;

endpackage

// File: rtl/fp_mag_compare.sv
// Combinational sign/magnitude "a greater than b" decision.
// The magnitude is the raw {exponent, significand} field. No normalization is applied.
// A zero magnitude counts as zero whatever its sign bit is.
module fp_mag_compare
  import fp_greaterthan_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic [EXP_W+SIG_W:0] a,
  input  logic [EXP_W+SIG_W:0] b,
  output logic                 a_gt_b
);

  localparam int W = 1 + EXP_W + SIG_W;

  logic [W-2:0] mag_a;
  logic [W-2:0] mag_b;
  logic         neg_a;
  logic         neg_b;

  // Only a set sign bit on a nonzero magnitude makes a value negative.
  // This makes -0 compare equal to +0.
  always_comb begin
    mag_a  = a[W-2:0];
    mag_b  = b[W-2:0];
    neg_a  = a[W-1] && (mag_a != '0);
    neg_b  = b[W-1] && (mag_b != '0);
    a_gt_b = 1'b0;
    case ({neg_a, neg_b})
      2'b00:   a_gt_b = (mag_a > mag_b);
      2'b01:   a_gt_b = 1'b1;
      2'b10:   a_gt_b = 1'b0;
      default: a_gt_b = (mag_a < mag_b);
    endcase
  end

endmodule

// File: rtl/fp_greaterthan.sv
// Registered floating-point "first > second" comparator. Latency is 1 and throughput is 1 per cycle.
// Optional build macro: FP_GREATERTHAN_INPUT_CHECK_EN adds the registered err output.
// err flags any operand that has a nonzero magnitude but a clear significand MSB.
// Handshake: in_valid marks the operands sampled on a rising edge. out_valid is
// in_valid delayed by one cycle. There is no backpressure. While out_valid is low,
// gt keeps its previous value.
module fp_greaterthan
  import fp_greaterthan_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [EXP_W+SIG_W:0] first,
  input  logic [EXP_W+SIG_W:0] second,
  output logic                 out_valid,
  output logic                 gt
`ifdef FP_GREATERTHAN_INPUT_CHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int W = 1 + EXP_W + SIG_W;

  logic cmp_gt;
  logic out_valid_d, out_valid_q;
  logic gt_d, gt_q;

  fp_mag_compare #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_cmp (
    .a      (first),
    .b      (second),
    .a_gt_b (cmp_gt)
  );

  // Capture a new result only when operands are valid; otherwise hold gt
  always_comb begin
    out_valid_d = in_valid;
    gt_d        = in_valid ? cmp_gt : gt_q;
  end

  // Result registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      gt_q        <= gt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gt        = gt_q;

`ifdef FP_GREATERTHAN_INPUT_CHECK_EN
  logic err_d, err_q;
  logic bad_a, bad_b;

  // Flag an unnormalized operand: nonzero magnitude with a clear leading significand bit
  always_comb begin
    bad_a = (first[W-2:0]  != '0) && !first[SIG_W-1];
    bad_b = (second[W-2:0] != '0) && !second[SIG_W-1];
    err_d = in_valid ? (bad_a || bad_b) : err_q;
  end

  // err is registered alongside gt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_fp_greaterthan.sv
// Testbench for fp_greaterthan with the default 13-bit word.
module tb_fp_greaterthan;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [12:0] first;
  logic [12:0] second;
  logic        out_valid;
  logic        gt;
`ifdef FP_GREATERTHAN_INPUT_CHECK_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  // {expected out_valid, expected gt}: one entry for each driven cycle
  logic [1:0] exp_q[$];
  logic       model_gt = 1'b0;

  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    logic        exp_gt;
  } vec_t;

  vec_t vecs[11];

  fp_greaterthan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .first     (first),
    .second    (second),
    .out_valid (out_valid),
    .gt        (gt)
`ifdef FP_GREATERTHAN_INPUT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare the operands as signed integers.
  // A zero magnitude maps to 0 whatever its sign bit is.
  function automatic logic ref_gt(input logic [12:0] a, input logic [12:0] b);
    int va;
    int vb;
    va = int'(a[11:0]);
    vb = int'(b[11:0]);
    if (a[12]) va = -va;
    if (b[12]) vb = -vb;
    return va > vb;
  endfunction

  // Drive one cycle of stimulus on the falling edge and record the expectation
  task automatic drive(input logic v, input logic [12:0] a, input logic [12:0] b,
                       input logic e);
    @(negedge clk);
    in_valid = v;
    first    = a;
    second   = b;
    if (v) model_gt = e;
    exp_q.push_back({v, model_gt});
  endtask

  // Scoreboard: just after each rising edge, compare against the oldest expectation
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_valid", out_valid, e[1]);
      check("gt", gt, e[0]);
    end
  end

  initial begin
    logic [12:0] a;
    logic [12:0] b;
    logic [11:0] m;
    int wait_cnt;

    vecs[0]  = '{13'b0_1111_11111111, 13'b0_1111_11111110, 1'b1};
    vecs[1]  = '{13'b1_1111_11111111, 13'b0_1111_11111110, 1'b0};
    vecs[2]  = '{13'b0_1111_11111111, 13'b1_1111_11111110, 1'b1};
    vecs[3]  = '{13'b1_0101_10000001, 13'b1_0101_10000000, 1'b0};
    vecs[4]  = '{13'b1_0101_10000000, 13'b1_0101_10000001, 1'b1};
    vecs[5]  = '{13'b0_0000_00000000, 13'b1_0000_00000000, 1'b0};
    vecs[6]  = '{13'b1_0000_00000000, 13'b0_0000_00000000, 1'b0};
    vecs[7]  = '{13'b0_0011_10100000, 13'b0_0011_10100000, 1'b0};
    vecs[8]  = '{13'b0_0000_00000001, 13'b1_0000_00000000, 1'b1};
    vecs[9]  = '{13'b0_0001_01000000, 13'b0_0000_11111111, 1'b1};
    vecs[10] = '{13'b1_0000_00000000, 13'b1_0000_00000001, 1'b1};

    in_valid = 1'b0;
    first    = '0;
    second   = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_gt", gt, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, applied back to back
    for (int i = 0; i < 11; i++) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp_gt);
    // Idle cycles: out_valid drops and gt holds its last value (1)
    drive(1'b0, 13'h1fff, 13'h0000, 1'b0);
    drive(1'b0, 13'h0000, 13'h1fff, 1'b0);
    // A gap followed by a single valid cycle
    drive(1'b1, 13'b0_0000_00000000, 13'b0_0000_00000001, 1'b0);
    drive(1'b0, 13'h0000, 13'h0000, 1'b0);

    // Asynchronous reset mid-stream with a gt=1 result pending in the output
    drive(1'b1, 13'b0_0000_00000001, 13'b1_0000_00000000, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_gt", gt, 1'b0);
    model_gt = 1'b0;
    // Operands held valid during reset must be discarded
    @(posedge clk);
    #1;
    check("rst_discard_out_valid", out_valid, 1'b0);
    check("rst_discard_gt", gt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // The still-valid operand is sampled on the first edge after release
    model_gt = 1'b1;
    exp_q.push_back({1'b1, 1'b1});

    // Sweep every (i, i-1) magnitude pair in all four sign combinations, back to back
    for (int s = 0; s < 4; s++) begin
      for (int i = 1; i < 4096; i++) begin
        m = 12'(i);
        a = {s[1], m};
        m = 12'(i - 1);
        b = {s[0], m};
        drive(1'b1, a, b, ref_gt(a, b));
      end
    end
    drive(1'b0, 13'h0000, 13'h0000, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_greaterthan.md
FP_GREATERTHAN -- requirements
Module: fp_greaterthan

Interface
REQ-001 SHALL have parameter EXP_W, default 4, exponent field width.
REQ-002 SHALL have parameter SIG_W, default 8, significand field width; word width W = 1+EXP_W+SIG_W (13 by default).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands valid this cycle.
REQ-006 SHALL have port first, input, W, operand A: [W-1] sign, [W-2:SIG_W] unsigned exponent, [SIG_W-1:0] normalized significand.
REQ-007 SHALL have port second, input, W, operand B, same format.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port gt, output, 1, 1 when first > second numerically.

Function
REQ-010 SHALL define magnitude as the unsigned {exponent, significand} field (bits W-2:0); larger field is larger magnitude.
REQ-011 SHALL treat magnitude 0 as zero regardless of sign; +0 and -0 compare equal (gt=0 either order).
REQ-012 SHALL compute gt: both non-negative -> magA > magB; A positive/zero, B negative nonzero -> 1; A negative nonzero, B positive/zero -> 0; both negative -> magA < magB.
REQ-013 SHALL produce gt=0 for equal operands.
REQ-014 SHALL register the result: gt and out_valid update one clk after in_valid sampled high (latency 1, throughput 1/cycle).
REQ-015 SHALL drive out_valid low the cycle after in_valid is sampled low; gt holds its last value while out_valid is low.
REQ-016 SHALL compare unnormalized nonzero encodings by raw field value, with no normalization.
REQ-017 SHALL have no backpressure; back-to-back operands produce back-to-back results.

Reset
REQ-018 SHALL clear gt and out_valid to 0 immediately on rst_n low, independent of clk.
REQ-019 SHALL discard an operand sampled in the reset-release cycle only if rst_n is still low at that edge; first valid result follows the first in_valid sampled with rst_n high.

Configuration
REQ-020 SHALL, with macro FP_GREATERTHAN_INPUT_CHECK_EN defined, add output err (1 bit, registered with gt, reset 0) set when either operand has nonzero magnitude but significand MSB 0.
REQ-021 SHALL, without FP_GREATERTHAN_INPUT_CHECK_EN, have no err port; gt behaviour identical in both builds.

Structure
REQ-022 SHALL put EXP_W/SIG_W defaults, field-position constants and an fp word typedef in package fp_greaterthan_pkg.
REQ-023 SHALL implement the combinational sign/magnitude decision in sub-module fp_mag_compare (inputs a, b; output a_gt_b), with fp_greaterthan adding only registers and the optional check.

Verification
REQ-024 SHALL check pos-pos: first=0_1111_11111111, second=0_1111_11111110 -> gt=1 one cycle later.
REQ-025 SHALL check neg-pos: first=1_1111_11111111, second=0_1111_11111110 -> gt=0; and pos-neg with same magnitudes -> gt=1.
REQ-026 SHALL check neg-neg: first=1_0101_10000001, second=1_0101_10000000 -> gt=0; swapped -> gt=1.
REQ-027 SHALL check zeros and equality: +0 vs -0, -0 vs +0, 0_0011_10100000 vs itself -> gt=0 in all.
REQ-028 SHALL sweep all 4095 consecutive magnitude pairs (i, i-1) in all four sign combinations, back-to-back, comparing against a reference model each cycle.
REQ-029 SHALL check async reset mid-stream: rst_n low between edges -> gt=0 and out_valid=0 immediately, results resume after release.
